// File: rtl/reduce_sequencer_pkg.sv
// reduce_sequencer shared definitions:
// ALU op codes, FSM states and command legality helper.
package reduce_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_WB,
        S_STORE,
        S_DONE
    } state_t;

    function automatic logic is_legal_op(input logic [3:0] op);
        return (op == ALU_AND) || (op == ALU_OR) ||
               (op == ALU_ADD) || (op == ALU_SUB);
    endfunction

endpackage

// File: rtl/reduce_sequencer_if.sv
// Command, status, register-file and memory bundle
// between the reduce engine and its datapath.
interface reduce_sequencer_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int MEM_AW = 7
);
    logic              start;
    logic [3:0]        op;
    logic [REG_AW-1:0] src_base;
    logic [REG_AW-1:0] count;
    logic [REG_AW-1:0] dst_reg;
    logic              store_en;
    logic [MEM_AW-1:0] store_addr;
    logic              busy;
    logic              done;
    logic              err;
    logic              ovf;
    logic [DATA_W-1:0] result;
    logic [REG_AW-1:0] rf_read_reg;
    logic [DATA_W-1:0] rf_read_data;
    logic              rf_write;
    logic [REG_AW-1:0] rf_write_reg;
    logic [DATA_W-1:0] rf_write_data;
    logic              mem_write;
    logic [MEM_AW-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    modport master (
        output start, op, src_base, count, dst_reg,
        output store_en, store_addr, rf_read_data,
        input  busy, done, err, ovf, result,
        input  rf_read_reg, rf_write, rf_write_reg,
        input  rf_write_data, mem_write, mem_addr, mem_wdata
    );

    modport slave (
        input  start, op, src_base, count, dst_reg,
        input  store_en, store_addr, rf_read_data,
        output busy, done, err, ovf, result,
        output rf_read_reg, rf_write, rf_write_reg,
        output rf_write_data, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/reduce_alu.sv
// Single-step fold operator with signed overflow flag
// (overflow only meaningful for ADD/SUB, else 0).
module reduce_alu
    import reduce_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y,
    output logic              ovf
);
    localparam int MSB = DATA_W - 1;

    // combinational op(a,b) and overflow detect
    always_comb begin
        y   = '0;
        ovf = 1'b0;
        case (op)
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_ADD: begin
                y   = a + b;
                ovf = (a[MSB] == b[MSB]) && (y[MSB] != a[MSB]);
            end
            ALU_SUB: begin
                y   = a - b;
                ovf = (a[MSB] != b[MSB]) && (y[MSB] != a[MSB]);
            end
            default: y = '0;
        endcase
    end
endmodule

// File: rtl/reduce_sequencer.sv
// Multi-cycle register-run reduction engine:
// fold src_base..src_base+count-1, write back, optionally store.
module reduce_sequencer
    import reduce_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int MEM_AW = 7
) (
    input  logic               clock,
    input  logic               reset,
    reduce_sequencer_if.slave  bus
);
    localparam logic [REG_AW:0] NREG = {1'b1, {REG_AW{1'b0}}};

    state_t            state_q, state_d;
    logic [3:0]        op_q;
    logic [REG_AW-1:0] base_q, cnt_q, dst_q, i_q;
    logic              st_en_q;
    logic [MEM_AW-1:0] st_addr_q;
    logic [DATA_W-1:0] acc_q, res_q, alu_y;
    logic              err_q, ovf_q, alu_ovf;
    logic              accept, legal, last;
    logic [REG_AW:0]   span;

    assign span   = {1'b0, bus.src_base} + {1'b0, bus.count};
    assign legal  = is_legal_op(bus.op) && (bus.count != '0) &&
                    (span <= NREG);
    assign accept = (state_q == S_IDLE) && bus.start;
    assign last   = (i_q == cnt_q - REG_AW'(1));

    reduce_alu #(.DATA_W(DATA_W)) u_alu (
        .op (op_q),
        .a  (acc_q),
        .b  (bus.rf_read_data),
        .y  (alu_y),
        .ovf(alu_ovf)
    );

    // state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = legal ? S_RUN : S_DONE;
            S_RUN:   if (last) state_d = S_WB;
            S_WB:    state_d = st_en_q ? S_STORE : S_DONE;
            S_STORE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // command latch, operand counter, accumulator and flags
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_q      <= '0;
            base_q    <= '0;
            cnt_q     <= '0;
            dst_q     <= '0;
            st_en_q   <= 1'b0;
            st_addr_q <= '0;
            i_q       <= '0;
            acc_q     <= '0;
            res_q     <= '0;
            err_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else if (accept) begin
            op_q      <= bus.op;
            base_q    <= bus.src_base;
            cnt_q     <= bus.count;
            dst_q     <= bus.dst_reg;
            st_en_q   <= bus.store_en;
            st_addr_q <= bus.store_addr;
            i_q       <= '0;
            acc_q     <= '0;
            res_q     <= '0;
            err_q     <= !legal;
            ovf_q     <= 1'b0;
        end else begin
            if (state_q == S_RUN) begin
                i_q   <= i_q + REG_AW'(1);
                acc_q <= (i_q == '0) ? bus.rf_read_data : alu_y;
                if (i_q != '0 && alu_ovf) ovf_q <= 1'b1;
            end
            if (state_q != S_DONE && state_d == S_DONE)
                res_q <= acc_q;
        end
    end

    // state-decoded outputs; buses idle at zero
    always_comb begin
        bus.busy          = (state_q != S_IDLE);
        bus.done          = (state_q == S_DONE);
        bus.err           = err_q;
        bus.ovf           = ovf_q;
        bus.result        = res_q;
        bus.rf_read_reg   = '0;
        bus.rf_write      = 1'b0;
        bus.rf_write_reg  = '0;
        bus.rf_write_data = '0;
        bus.mem_write     = 1'b0;
        bus.mem_addr      = '0;
        bus.mem_wdata     = '0;
        case (state_q)
            S_RUN: bus.rf_read_reg = base_q + i_q;
            S_WB: begin
                bus.rf_write      = 1'b1;
                bus.rf_write_reg  = dst_q;
                bus.rf_write_data = acc_q;
            end
            S_STORE: begin
                bus.mem_write = 1'b1;
                bus.mem_addr  = st_addr_q;
                bus.mem_wdata = acc_q;
            end
            default: ;
        endcase
    end
endmodule

// File: doc/reduce_sequencer.md
# reduce_sequencer

Multi-cycle reduction engine that sits beside the register file and data memory of the MIPS datapath. It replaces hand-sequenced chains of R-type ADDs followed by a store. On a start pulse it reads a contiguous run of registers, folds them with one ALU operation, writes the result to a destination register and, optionally, to a data-memory word. The block is parametrised in data width, register count, memory depth and operation.

## Interface
- DATA_W, 32, datapath width
- REG_AW, 5, register index width (2^REG_AW registers)
- MEM_AW, 7, data-memory word address width
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; returns block to IDLE
- start  in  1  command strobe; sampled only in IDLE
- op  in  4  ALUCtl encoding: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB
- src_base  in  REG_AW  first source register
- count  in  REG_AW  number of operands, 1..2^REG_AW-1
- dst_reg  in  REG_AW  destination register
- store_en  in  1  also write result to memory
- store_addr  in  MEM_AW  memory word address
- busy  out  1  high from the cycle after start acceptance until DONE exits
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done; command rejected
- ovf  out  1  valid with done; sticky signed overflow (ADD/SUB only)
- result  out  DATA_W  final accumulator; held until next accepted start
- rf_read_reg  out  REG_AW  to RegFile ReadReg1
- rf_read_data  in  DATA_W  combinational ReadData1
- rf_write  out  1  RegWrite
- rf_write_reg  out  REG_AW  WriteReg
- rf_write_data  out  DATA_W  WriteData
- mem_write  out  1  MemWrite
- mem_addr  out  MEM_AW  memory address
- mem_wdata  out  DATA_W  memory write data

## Operation
- States: IDLE, RUN, WB, STORE, DONE.
- IDLE: if start=1, latch op, src_base, count, dst_reg, store_en and store_addr, and clear ovf.
  - Command legal: go to RUN with i=0.
  - Command illegal (op not in the set, count=0, or src_base+count > 2^REG_AW, computed REG_AW+1 bits wide): set err and go to DONE. No RF or memory access occurs.
- RUN: rf_read_reg = src_base+i.
  - Each edge: acc <= (i==0) ? rf_read_data : acc op rf_read_data.
  - i increments. After the edge with i=count-1, go to WB.
- SUB is left fold: r[b] - r[b+1] - ...
- ovf is set on any ADD/SUB step with signed overflow. It stays 0 for AND/OR.
- Wrap-around: arithmetic is modulo 2^DATA_W. No saturation.
- WB: rf_write=1, rf_write_reg=dst_reg, rf_write_data=acc. Next state is STORE if store_en, else DONE.
- STORE: mem_write=1, mem_addr=store_addr, mem_wdata=acc. Next state is DONE.
- DONE: done=1, result=acc, err/ovf valid. Next state is IDLE.
- dst_reg may lie inside the source range: all reads complete before WB, so sources are never corrupted mid-fold.
- start outside IDLE is ignored. No queueing.

## Timing
- Reset (async assert, sync-safe release): state=IDLE. busy, done, err, ovf, rf_write and mem_write = 0. result, acc, rf_* and mem_* buses = 0.
- Reset mid-operation: no write strobe is issued after assertion, and a partially folded value is never written.
- start accepted at edge E0. RUN occupies cycles 1..count, WB is cycle count+1, STORE is count+2 (if enabled). done is high in cycle count+2+store_en.
- Illegal command: done/err are high in cycle 1 after acceptance.
- rf_write and mem_write are each high for exactly one cycle per command.
- Register read path is combinational (RegFile style). The RF write lands at the WB→next edge.

## Structure
- Shared package reduce_pkg holds:
  - ALU op constants ALU_AND, ALU_OR, ALU_ADD, ALU_SUB (4-bit)
  - state enum
  - function is_legal_op
- One sub-module, reduce_alu: combinational op(a,b) plus signed-overflow output, DATA_W-parametrised. The FSM, counter and accumulator stay in reduce_sequencer.

## Test plan
- ADD fold: preload r1..r6 = 5,2,0,5,6,3; start with op=0010, src_base=1, count=6, dst_reg=31, store_en=1, store_addr=0. Required: r31=21, mem[0]=21, done in cycle 9, err=0, ovf=0.
- SUB fold: same registers, op=0110, store_en=0. Required: result=0xFFFFFFF5 (-11), done in cycle 8, mem_write never high.
- Overflow: r1=0x7FFFFFFF, r2=1, ADD, count=2. Required: result=0x80000000, ovf=1.
- Illegal command: count=0, then src_base=30 with count=3, then op=0111. Each required to give done with err=1 in cycle 1, with rf_write=0 and mem_write=0.
- Reset mid-run: assert reset during RUN of a count=6 ADD. Required: all outputs 0 immediately and r31/mem unchanged. A new command after release completes normally.
- Start while busy: pulse start with different operands during RUN. Required: ignored, and the original result is written.
